draw_rect_char: RTL and testbench
=================================

DRAW_RECT_CHAR -- requirements
Module: draw_rect_char

Interface
REQ-001 Parameter XPOS, default 100, meaning: hcount of the text box's left edge.
REQ-002 Parameter YPOS, default 50, meaning: vcount of the text box's top edge.
REQ-003 Parameter TEXT_COLOR, default 12'hFFF, meaning: RGB444 colour of lit glyph pixels.
REQ-004 clk  in  1  pixel clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hcount_in / vcount_in  in  11 each  horizontal / vertical pixel position.
REQ-007 hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  VGA timing flags.
REQ-008 rgb_in  in  12  background pixel colour.
REQ-009 hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out  out  widths as inputs  delayed timing and composited colour.
REQ-010 char_xy  out  8  character-grid address to the text ROM: [7:4] row, [3:0] column.
REQ-011 char_code  in  7  ASCII code returned by the text ROM, registered one clk after char_xy.

Function
REQ-012 The text box SHALL be 128 x 256 pixels: 16 columns x 16 rows of 8x16-pixel glyphs.
REQ-013 in_box SHALL be 1 iff XPOS <= hcount_in <= XPOS+127 and YPOS <= vcount_in <= YPOS+255, compared unsigned at 11 bits.
REQ-014 rel_x = hcount_in - XPOS and rel_y = vcount_in - YPOS SHALL be 11-bit; only rel_x[6:0] and rel_y[7:0] are used.
REQ-015 Cycle 1: char_xy SHALL register {rel_y[7:4], rel_x[6:3]} when in_box=1, else 8'h00. rel_x[2:0], rel_y[3:0] and in_box are registered alongside.
REQ-016 Cycle 2: char_code is valid. font_rom address SHALL be {char_code, rel_y[3:0] delayed 1 stage} (11 bits).
REQ-017 Cycle 3: the 8-bit font row is valid. The glyph bit SHALL be font_row[7 - rel_x[2:0]] (MSB = leftmost pixel), using rel_x delayed 2 stages.
REQ-018 Cycle 4, output register: rgb_out SHALL be TEXT_COLOR if delayed in_box=1 and glyph bit=1, else rgb_in delayed 4 clk.
REQ-019 All hcount/vcount/sync/blank outputs SHALL equal the corresponding inputs delayed exactly 4 clk, through a shift pipeline.
REQ-020 Blanking SHALL NOT alter compositing; rgb passes through unchanged where no glyph pixel lies.
REQ-021 Boundary pixels hcount=XPOS+127 and vcount=YPOS+255 SHALL be inside; XPOS+128 and YPOS+256 SHALL be outside.
REQ-022 The block SHALL accept a new pixel every clk with no stalls; throughput is 1 pixel/clk.

Reset
REQ-023 While rst=1 at a rising edge, every pipeline register and output SHALL go to 0: char_xy=8'h00, rgb_out=12'h000, all timing outputs 0.
REQ-024 Reset mid-frame SHALL flush the pipeline. The first valid output appears on the 4th edge after rst deasserts. No partial glyph data leaks out.

Structure
REQ-025 vga_pkg SHALL hold CHAR_W=8, CHAR_H=16, TEXT_COLS=16, TEXT_ROWS=16 and DRAW_CHAR_LATENCY=4.
REQ-026 The glyph bitmap SHALL be a separate sub-module font_rom: 11-bit address in, 8-bit row out, registered with 1-clk latency, instantiated inside draw_rect_char.
REQ-027 The text ROM stays external and connects via char_xy and char_code.

Verification
REQ-028 hcount_in=100, vcount_in=50 (defaults) -> char_xy=8'h00 one clk later.
REQ-029 hcount_in=227, vcount_in=305 -> char_xy=8'hFF; hcount_in=228 -> in_box=0, char_xy=8'h00, rgb_out=rgb_in 4 clk later.
REQ-030 char_code model returns 7'h4C ('L'), rgb_in=12'h123 -> over each 8x16 cell, rgb_out=12'hFFF exactly where the font_rom 'L' bits are 1, else 12'h123.
REQ-031 Single-clk pulse on hsync_in at cycle n, with hcount ramping 0..N -> hsync_out pulse at n+4, and hcount_out equals hcount_in from 4 clk earlier.
REQ-032 Assert rst for 1 clk mid-line inside the box -> all outputs 0 on the following edge; correct compositing resumes on the 4th edge after deassert.
REQ-033 Full 800x600 frame against a reference model, with a random text ROM -> zero pixel mismatches.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA text-overlay constants and the timing/colour bundle carried down
// the draw_rect_char delay pipeline.
package vga_pkg;
  localparam int CHAR_W            = 8;
  localparam int CHAR_H            = 16;
  localparam int TEXT_COLS         = 16;
  localparam int TEXT_ROWS         = 16;
  localparam int DRAW_CHAR_LATENCY = 4;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;
endpackage

// File: rtl/draw_rect_char_font_rom.sv
// Glyph bitmap ROM: {char_code, glyph_row} in, 8-pixel row out one clk later.
// Only 'L' carries pixels; every other code renders blank.
module font_rom (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [7:0] data_d, data_q;

  always_comb begin
    data_d = 8'h00;
    if (addr[10:4] == 7'h4C) begin
      if (addr[3:0] >= 4'h2 && addr[3:0] <= 4'hC) data_d = 8'h60;
      else if (addr[3:0] == 4'hD)                 data_d = 8'h7E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data = data_q;
endmodule

// File: rtl/draw_rect_char.sv
// Overlays a 16x16 character text box onto a VGA pixel stream. Four-stage
// pipeline: grid address -> external text ROM -> font_rom -> colour mux.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter int          XPOS       = 100,
  parameter int          YPOS       = 50,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code
);
  localparam int          LAT = DRAW_CHAR_LATENCY;
  localparam logic [10:0] X0  = 11'(XPOS);
  localparam logic [10:0] X1  = 11'(XPOS + CHAR_W * TEXT_COLS - 1);
  localparam logic [10:0] Y0  = 11'(YPOS);
  localparam logic [10:0] Y1  = 11'(YPOS + CHAR_H * TEXT_ROWS - 1);

  // Only the low bits of the offsets are ever used, so subtract at that width.
  logic [6:0] rel_x;
  logic [7:0] rel_y;
  logic       in_box;

  assign rel_x  = hcount_in[6:0] - X0[6:0];
  assign rel_y  = vcount_in[7:0] - Y0[7:0];
  assign in_box = (hcount_in >= X0) && (hcount_in <= X1) &&
                  (vcount_in >= Y0) && (vcount_in <= Y1);

  vga_bus_t   bus_d [LAT];
  vga_bus_t   bus_q [LAT];
  logic [7:0] char_xy_d, char_xy_q;
  logic [2:0] rx_d [3];
  logic [2:0] rx_q [3];
  logic [3:0] ry_d [2];
  logic [3:0] ry_q [2];
  logic       inbox_d [3];
  logic       inbox_q [3];
  logic [7:0] font_row;
  logic       glyph_bit;

  font_rom u_font_rom (
    .clk  (clk),
    .rst  (rst),
    .addr ({char_code, ry_q[1]}),
    .data (font_row)
  );

  assign glyph_bit = font_row[3'd7 - rx_q[2]];

  always_comb begin
    char_xy_d  = in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
    rx_d[0]    = rel_x[2:0];
    rx_d[1]    = rx_q[0];
    rx_d[2]    = rx_q[1];
    ry_d[0]    = rel_y[3:0];
    ry_d[1]    = ry_q[0];
    inbox_d[0] = in_box;
    inbox_d[1] = inbox_q[0];
    inbox_d[2] = inbox_q[1];

    bus_d[0] = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                 hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};
    for (int i = 1; i < LAT; i++) bus_d[i] = bus_q[i-1];
    // Last stage is the output register: the glyph colour replaces background.
    if (inbox_q[2] && glyph_bit) bus_d[LAT-1].rgb = TEXT_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_xy_q <= 8'h00;
      for (int i = 0; i < LAT; i++) bus_q[i]   <= '0;
      for (int i = 0; i < 3; i++)   rx_q[i]    <= '0;
      for (int i = 0; i < 2; i++)   ry_q[i]    <= '0;
      for (int i = 0; i < 3; i++)   inbox_q[i] <= 1'b0;
    end else begin
      char_xy_q <= char_xy_d;
      for (int i = 0; i < LAT; i++) bus_q[i]   <= bus_d[i];
      for (int i = 0; i < 3; i++)   rx_q[i]    <= rx_d[i];
      for (int i = 0; i < 2; i++)   ry_q[i]    <= ry_d[i];
      for (int i = 0; i < 3; i++)   inbox_q[i] <= inbox_d[i];
    end
  end

  assign char_xy    = char_xy_q;
  assign hcount_out = bus_q[LAT-1].hcount;
  assign vcount_out = bus_q[LAT-1].vcount;
  assign hsync_out  = bus_q[LAT-1].hsync;
  assign hblnk_out  = bus_q[LAT-1].hblnk;
  assign vsync_out  = bus_q[LAT-1].vsync;
  assign vblnk_out  = bus_q[LAT-1].vblnk;
  assign rgb_out    = bus_q[LAT-1].rgb;
endmodule

// File: tb/tb_draw_rect_char.sv
// Directed bench for draw_rect_char with default parameters; an external
// text ROM model serves a checkerboard of 'L' and space.
module tb_draw_rect_char;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;

  int checks = 0;
  int errors = 0;
  logic [37:0] expq[$];

  draw_rect_char dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .char_xy(char_xy), .char_code(char_code)
  );

  always #5 clk = ~clk;

  // Registered text ROM: 'L' where row and column parity match, else space.
  always @(posedge clk) char_code <= (char_xy[0] == char_xy[4]) ? 7'h4C : 7'h20;

  function automatic logic glyph_lit(input logic [6:0] code, input int gx, input int gy);
    if (code != 7'h4C) return 1'b0;
    if (gy >= 2 && gy <= 12) return (gx == 1 || gx == 2);
    if (gy == 13) return (gx >= 1 && gx <= 6);
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] outs();
    return {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};
  endfunction

  task automatic restart_queue();
    expq.delete();
    repeat (3) expq.push_back(38'd0);
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs,
                       input logic hb, input logic vs, input logic vb, input logic [11:0] rgb,
                       input string tag);
    int rx, ry;
    logic inb;
    logic [7:0] xy;
    logic [6:0] code;
    logic [11:0] ergb;
    rx  = int'(h) - 100;
    ry  = int'(v) - 50;
    inb = (rx >= 0) && (rx <= 127) && (ry >= 0) && (ry <= 255);
    xy  = inb ? {4'(ry >> 4), 4'(rx >> 3)} : 8'h00;
    code = (xy[0] == xy[4]) ? 7'h4C : 7'h20;
    ergb = (inb && glyph_lit(code, rx % 8, ry % 16)) ? 12'hFFF : rgb;
    hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
    vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    expq.push_back({h, v, hs, hb, vs, vb, ergb});
    tick();
    chk({tag, "_char_xy"}, 64'(char_xy), 64'(xy));
    if (expq.size() == 4) chk({tag, "_out"}, 64'(outs()), 64'(expq.pop_front()));
  endtask

  task automatic flush();
    repeat (4) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "flush");
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = 11'd120; vcount_in = 11'd60; hsync_in = 1'b1; hblnk_in = 1'b1;
    vsync_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'hABC;
    tick(); tick();
    chk("reset_out", 64'(outs()), 64'd0);
    chk("reset_char_xy", 64'(char_xy), 64'd0);
    rst = 1'b0;
    restart_queue();

    // First cell plus left margin and the start of the second cell.
    for (int y = 50; y <= 65; y++)
      for (int x = 98; x <= 109; x++)
        drive(11'(x), 11'(y), 1'b0, 1'(x), 1'b0, 1'b0, 12'h123, "cell0");

    // Bottom-right corner: last row/column inside, one beyond each outside.
    for (int y = 303; y <= 306; y++)
      for (int x = 219; x <= 229; x++)
        drive(11'(x), 11'(y), 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, "corner");

    // Single-clk hsync pulse on a ramping hcount outside the box.
    for (int x = 0; x <= 20; x++)
      drive(11'(x), 11'd0, 1'(x == 7), 1'b0, 1'(x > 15), 1'b1, 12'(x * 37), "sync");

    // Mid-line reset inside the box, then resume on the same line.
    for (int x = 100; x <= 105; x++)
      drive(11'(x), 11'd63, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, "pre_rst");
    rst = 1'b1;
    hcount_in = 11'd106;
    tick();
    chk("midrst_out", 64'(outs()), 64'd0);
    chk("midrst_char_xy", 64'(char_xy), 64'd0);
    rst = 1'b0;
    restart_queue();
    for (int x = 106; x <= 118; x++)
      drive(11'(x), 11'd63, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, "post_rst");

    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
